multi_channel_sensor_accel: RTL and testbench
=============================================

MULTI_CHANNEL_SENSOR_ACCEL -- requirements
Module: multi_channel_sensor_accel

Interface
REQ-001 Parameter WIDTH, 16, sample width in bits (8..24).
REQ-002 Parameter CHANNELS, 4, number of independent sensor channels (1..8).
REQ-003 Parameter WIN_LOG2, 3, log2 of moving-average window depth (1..5).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 cyc_i, stb_i, we_i  input  1 each  Wishbone slave cycle, strobe, write-enable.
REQ-007 adr_i  input  6  word address.
REQ-008 dat_i  input  32  write data; dat_o  output  32  read data.
REQ-009 ack_o  output  1  Wishbone acknowledge.
REQ-010 irq_o  output  1  level interrupt.
REQ-011 sensor_data_in  input  CHANNELS*WIDTH  channel c at bits [c*WIDTH +: WIDTH].
REQ-012 sensor_valid_in  input  CHANNELS  per-channel sample strobe.

Function
REQ-013 Register map: 0x00 CTRL (bit0 enable, bit1 clear, write-only self-clearing); 0x01 IRQ_EN[CHANNELS-1:0]; 0x02 IRQ_STATUS (W1C); 0x03 EVENT_STATE (RO); 0x08+4c THRESH_HI[c]; 0x09+4c THRESH_LO[c]; 0x0A+4c FILTERED[c] (RO); 0x0B+4c FILL[c] (RO, samples in window).
REQ-014 Access accepted when cyc_i&stb_i&!ack_o; ack_o high exactly the following cycle for one cycle; no back-to-back acks.
REQ-015 Read data registered with the ack; unused bits zero; unmapped or channel index >= CHANNELS reads 0, writes ignored but acked.
REQ-016 Sample accepted for channel c only when enable=1 and sensor_valid_in[c]=1; otherwise channel state holds.
REQ-017 Per channel: shift register of 2^WIN_LOG2 samples; on accept, sum <= sum - oldest + new in one update (sum width WIDTH+WIN_LOG2, never overflows).
REQ-018 FILL[c] increments per accept, saturates at 2^WIN_LOG2; empty slots count as zero.
REQ-019 FILTERED[c] = sum >> WIN_LOG2, registered one cycle after the sum update (2 cycles accept-to-FILTERED).
REQ-020 Event evaluation only when FILL[c] is full: if FILTERED>=THRESH_HI then EVENT_STATE[c]<=1, else if FILTERED<=THRESH_LO then <=0, else hold; HI test has priority when LO>HI.
REQ-021 0->1 transition of EVENT_STATE[c] sets IRQ_STATUS[c]; set beats a same-cycle W1C on that bit.
REQ-022 irq_o registered = |(IRQ_STATUS & IRQ_EN); one cycle after status/enable change.
REQ-023 CTRL.clear: next cycle zeroes all windows, sums, FILL, FILTERED, EVENT_STATE, IRQ_STATUS; thresholds, IRQ_EN, enable retained; sample accepts in the clear cycle discarded.
REQ-024 Threshold writes take effect on the next evaluation; no retroactive interrupt.

Reset
REQ-025 On rst: ack_o=0, dat_o=0, irq_o=0, enable=0, IRQ_EN=0, IRQ_STATUS=0, EVENT_STATE=0, all windows/sums/FILL/FILTERED=0, THRESH_HI=1000, THRESH_LO=900 per channel.
REQ-026 rst mid-transaction drops ack_o immediately; the transaction is lost, master must retry.

Verification
REQ-027 Reset, read 0x08/0x09 -> 1000/900; read 0x0A -> 0; irq_o=0.
REQ-028 enable=1, ch0 samples 10,20..80 (8 valid pulses) -> FILL[0]=8, FILTERED[0]=45, EVENT_STATE=0.
REQ-029 HI=400, LO=200, IRQ_EN=1, ch0 eight samples of 450 -> EVENT_STATE[0]=1, IRQ_STATUS[0]=1, irq_o=1; ch1 unaffected.
REQ-030 Then eight samples of 300 -> EVENT_STATE[0] stays 1 (hysteresis); eight of 100 -> 0; W1C 0x02 bit0 -> irq_o=0 next cycle.
REQ-031 W1C on bit0 in same cycle as new 0->1 event -> IRQ_STATUS[0] remains 1.
REQ-032 CTRL.clear with ch2 full -> FILL[2]=0, FILTERED[2]=0, thresholds unchanged; unmapped 0x3F read -> 0 with ack.

Source files
------------

// File: rtl/multi_channel_sensor_accel.sv
// Multi-channel sensor front end: per-channel moving-average filter with
// hysteresis threshold events, sticky interrupt status and a Wishbone
// register interface.
//
// Wishbone handshake: a transfer is taken in any cycle where cyc_i & stb_i
// are high and ack_o is low; ack_o (with registered read data) follows for
// exactly one cycle, so back-to-back acks never occur. An asynchronous reset
// drops ack_o at once and the transfer is lost.
module multi_channel_sensor_accel #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4,
   parameter int WIN_LOG2 = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cyc_i,
   input  logic                         stb_i,
   input  logic                         we_i,
   input  logic [5:0]                   adr_i,
   input  logic [31:0]                  dat_i,
   output logic [31:0]                  dat_o,
   output logic                         ack_o,
   output logic                         irq_o,
   input  logic [CHANNELS*WIDTH-1:0]    sensor_data_in,
   input  logic [CHANNELS-1:0]          sensor_valid_in
);

   localparam int DEPTH  = 1 << WIN_LOG2;
   localparam int SUM_W  = WIDTH + WIN_LOG2;
   localparam int FILL_W = WIN_LOG2 + 1;
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
   localparam logic [WIDTH-1:0]  HI_RST    = WIDTH'(1000);
   localparam logic [WIDTH-1:0]  LO_RST    = WIDTH'(900);

   logic                access, wr, ctrl_wr, clear;
   logic [CHANNELS-1:0] w1c_mask, accept;
   logic                enable;
   logic [CHANNELS-1:0] irq_en, irq_status, event_state, event_next, rise;
   logic [WIDTH-1:0]    thresh_hi [CHANNELS];
   logic [WIDTH-1:0]    thresh_lo [CHANNELS];
   logic [WIDTH-1:0]    sample    [CHANNELS];
   logic [WIDTH-1:0]    win       [CHANNELS][DEPTH];
   logic [SUM_W-1:0]    sum       [CHANNELS];
   logic [FILL_W-1:0]   fill      [CHANNELS];
   logic [WIDTH-1:0]    filtered  [CHANNELS];
   // upd: sum changed last cycle; eval: filtered refreshed last cycle.
   // The *_full flags remember whether that sample completed the window.
   logic [CHANNELS-1:0] upd, upd_full, eval, eval_full;
   logic [31:0]         rd_data;
   logic                unused_bits;

   assign access      = cyc_i & stb_i & ~ack_o;
   assign wr          = access & we_i;
   assign ctrl_wr     = wr && (adr_i == 6'h00);
   assign clear       = ctrl_wr & dat_i[1];
   assign w1c_mask    = (wr && adr_i == 6'h02) ? dat_i[CHANNELS-1:0] : '0;
   assign accept      = enable ? sensor_valid_in : '0;
   assign rise        = event_next & ~event_state;
   assign unused_bits = ^dat_i;

   // Split the packed sample bus into per-channel lanes
   always_comb begin
      for (int c = 0; c < CHANNELS; c++) sample[c] = sensor_data_in[c*WIDTH +: WIDTH];
   end

   // Register read mux; unmapped addresses and absent channels read zero
   always_comb begin
      rd_data = '0;
      case (adr_i)
         6'h00:   rd_data[0] = enable;
         6'h01:   rd_data[CHANNELS-1:0] = irq_en;
         6'h02:   rd_data[CHANNELS-1:0] = irq_status;
         6'h03:   rd_data[CHANNELS-1:0] = event_state;
         default: rd_data = '0;
      endcase
      for (int c = 0; c < CHANNELS; c++) begin
         if (adr_i == 6'(8 + 4*c))  rd_data[WIDTH-1:0]  = thresh_hi[c];
         if (adr_i == 6'(9 + 4*c))  rd_data[WIDTH-1:0]  = thresh_lo[c];
         if (adr_i == 6'(10 + 4*c)) rd_data[WIDTH-1:0]  = filtered[c];
         if (adr_i == 6'(11 + 4*c)) rd_data[FILL_W-1:0] = fill[c];
      end
   end

   // Bus acknowledge, read data capture and host-written configuration
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_o  <= 1'b0;
         dat_o  <= '0;
         enable <= 1'b0;
         irq_en <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            thresh_hi[c] <= HI_RST;
            thresh_lo[c] <= LO_RST;
         end
      end else begin
         ack_o <= access;
         if (access) dat_o <= we_i ? 32'd0 : rd_data;
         if (ctrl_wr) enable <= dat_i[0];
         if (wr && adr_i == 6'h01) irq_en <= dat_i[CHANNELS-1:0];
         for (int c = 0; c < CHANNELS; c++) begin
            if (wr && adr_i == 6'(8 + 4*c)) thresh_hi[c] <= dat_i[WIDTH-1:0];
            if (wr && adr_i == 6'(9 + 4*c)) thresh_lo[c] <= dat_i[WIDTH-1:0];
         end
      end
   end

   // Sample windows, running sums, fill counts and filtered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < CHANNELS; c++) begin
            for (int i = 0; i < DEPTH; i++) win[c][i] <= '0;
            sum[c]      <= '0;
            fill[c]     <= '0;
            filtered[c] <= '0;
         end
         upd       <= '0;
         upd_full  <= '0;
         eval      <= '0;
         eval_full <= '0;
      end else if (clear) begin
         // samples arriving in the clear cycle are dropped
         for (int c = 0; c < CHANNELS; c++) begin
            for (int i = 0; i < DEPTH; i++) win[c][i] <= '0;
            sum[c]      <= '0;
            fill[c]     <= '0;
            filtered[c] <= '0;
         end
         upd       <= '0;
         upd_full  <= '0;
         eval      <= '0;
         eval_full <= '0;
      end else begin
         upd       <= accept;
         eval      <= upd;
         eval_full <= upd_full;
         for (int c = 0; c < CHANNELS; c++) begin
            upd_full[c] <= (fill[c] >= FILL_FULL - FILL_W'(1));
            if (accept[c]) begin
               win[c][0] <= sample[c];
               for (int i = 1; i < DEPTH; i++) win[c][i] <= win[c][i-1];
               // empty slots hold zero, so subtracting the oldest is always safe
               sum[c] <= sum[c] - SUM_W'(win[c][DEPTH-1]) + SUM_W'(sample[c]);
               if (fill[c] != FILL_FULL) fill[c] <= fill[c] + FILL_W'(1);
            end
            if (upd[c]) filtered[c] <= sum[c][WIN_LOG2 +: WIDTH];
         end
      end
   end

   // Hysteresis decision on each freshly filtered value of a full window
   always_comb begin
      event_next = event_state;
      for (int c = 0; c < CHANNELS; c++) begin
         if (eval[c] && eval_full[c]) begin
            if (filtered[c] >= thresh_hi[c])      event_next[c] = 1'b1;
            else if (filtered[c] <= thresh_lo[c]) event_next[c] = 1'b0;
         end
      end
   end

   // Event state, sticky status (a new event beats a same-cycle W1C) and irq
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         event_state <= '0;
         irq_status  <= '0;
         irq_o       <= 1'b0;
      end else begin
         if (clear) begin
            event_state <= '0;
            irq_status  <= '0;
         end else begin
            event_state <= event_next;
            irq_status  <= (irq_status & ~w1c_mask) | rise;
         end
         irq_o <= |(irq_status & irq_en);
      end
   end

endmodule

// File: tb/tb_multi_channel_sensor_accel.sv
// Bench for multi_channel_sensor_accel: directed register/filter/event steps
// followed by randomized multi-channel traffic, checked against a queue-based
// moving-average and hysteresis model.
module tb_multi_channel_sensor_accel;

   localparam int WIDTH = 16;
   localparam int CH    = 4;
   localparam int WL    = 3;
   localparam int DEPTH = 1 << WL;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
   logic [5:0]        adr_i = '0;
   logic [31:0]       dat_i = '0;
   logic [31:0]       dat_o;
   logic              ack_o, irq_o;
   logic [CH*WIDTH-1:0] sensor_data_in = '0;
   logic [CH-1:0]     sensor_valid_in = '0;

   multi_channel_sensor_accel #(.WIDTH(WIDTH), .CHANNELS(CH), .WIN_LOG2(WL)) dut (
      .clk(clk), .rst(rst), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
      .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o), .irq_o(irq_o),
      .sensor_data_in(sensor_data_in), .sensor_valid_in(sensor_valid_in)
   );

   // clock
   always #5 clk = ~clk;

   // watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // reference model: last DEPTH samples per channel, newest first
   int          m_win [CH][$];
   int          m_hi [CH];
   int          m_lo [CH];
   bit [CH-1:0] m_ev, m_st, m_en;
   bit          m_enable;

   function automatic int m_avg(int c);
      int s;
      s = 0;
      for (int i = 0; i < m_win[c].size(); i++) s += m_win[c][i];
      return s / DEPTH;
   endfunction

   function automatic void m_sample(int c, int v);
      int a;
      m_win[c].push_front(v);
      if (m_win[c].size() > DEPTH) void'(m_win[c].pop_back());
      if (m_win[c].size() == DEPTH) begin
         a = m_avg(c);
         if (a >= m_hi[c]) begin
            if (!m_ev[c]) m_st[c] = 1'b1;
            m_ev[c] = 1'b1;
         end else if (a <= m_lo[c]) begin
            m_ev[c] = 1'b0;
         end
      end
   endfunction

   function automatic void m_clear();
      for (int c = 0; c < CH; c++) m_win[c].delete();
      m_ev = '0;
      m_st = '0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // driver tasks: all start and end 1 time unit after a rising edge
   task automatic wb_access(input string tag, input logic w, input logic [5:0] a,
                            input logic [31:0] d, output logic [31:0] rd);
      bit got;
      got = 1'b0;
      rd  = '0;
      cyc_i = 1'b1; stb_i = 1'b1; we_i = w; adr_i = a; dat_i = d;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge clk); #1;
         if (ack_o) begin
            got = 1'b1;
            rd  = dat_o;
         end
      end
      cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
      check({tag, "_ack"}, 32'(got), 32'd1);
   endtask

   task automatic wb_write(input logic [5:0] a, input logic [31:0] d);
      logic [31:0] unused_rd;
      wb_access($sformatf("wr%02h", a), 1'b1, a, d, unused_rd);
   endtask

   task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
      logic [31:0] rd;
      wb_access(tag, 1'b0, a, 32'd0, rd);
      check(tag, rd, exp);
   endtask

   task automatic push(input logic [CH-1:0] vmask, input logic [CH*WIDTH-1:0] data);
      sensor_valid_in = vmask;
      sensor_data_in  = data;
      @(posedge clk); #1;
      sensor_valid_in = '0;
      if (m_enable)
         for (int c = 0; c < CH; c++)
            if (vmask[c]) m_sample(c, int'(data[c*WIDTH +: WIDTH]));
   endtask

   task automatic push1(input int c, input int v);
      logic [CH*WIDTH-1:0] d;
      d = '0;
      d[c*WIDTH +: WIDTH] = WIDTH'(v);
      push(CH'(1) << c, d);
   endtask

   task automatic settle();
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic chk_chan(input int c);
      rd_chk($sformatf("filtered%0d", c), 6'(10 + 4*c), 32'(m_avg(c)));
      rd_chk($sformatf("fill%0d", c), 6'(11 + 4*c), 32'(m_win[c].size()));
   endtask

   task automatic chk_glob(input string tag);
      rd_chk({tag, "_event"}, 6'h03, 32'(m_ev));
      rd_chk({tag, "_status"}, 6'h02, 32'(m_st));
      check({tag, "_irq"}, 32'(irq_o), 32'(|(m_st & m_en)));
   endtask

   // directed steps, then randomized rounds
   initial begin
      logic [CH-1:0]       vm;
      logic [CH*WIDTH-1:0] rd_data;
      logic [CH-1:0]       mask;

      for (int c = 0; c < CH; c++) begin
         m_hi[c] = 1000;
         m_lo[c] = 900;
      end
      m_ev = '0; m_st = '0; m_en = '0; m_enable = 1'b0;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_ack", 32'(ack_o), 32'd0);
      check("rst_dat", dat_o, 32'd0);
      check("rst_irq", 32'(irq_o), 32'd0);

      // reset in the middle of a transfer drops the acknowledge at once
      cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 6'h08;
      @(posedge clk); #1;
      check("ack_before_rst", 32'(ack_o), 32'd1);
      rst = 1'b1;
      #1;
      check("ack_dropped_by_rst", 32'(ack_o), 32'd0);
      cyc_i = 1'b0; stb_i = 1'b0;
      @(posedge clk); #1 rst = 1'b0;

      // reset register values
      rd_chk("thresh_hi0_rst", 6'h08, 32'd1000);
      rd_chk("thresh_lo0_rst", 6'h09, 32'd900);
      rd_chk("filtered0_rst", 6'h0A, 32'd0);
      check("irq_rst", 32'(irq_o), 32'd0);

      // samples are ignored while disabled
      push1(0, 55);
      settle();
      rd_chk("fill0_disabled", 6'h0B, 32'd0);

      // ramp 10..80 on channel 0
      wb_write(6'h00, 32'd1);
      m_enable = 1'b1;
      for (int k = 1; k <= 8; k++) push1(0, 10 * k);
      settle();
      rd_chk("fill0_ramp", 6'h0B, 32'd8);
      rd_chk("filtered0_ramp", 6'h0A, 32'd45);
      chk_glob("ramp");

      // crossing HI raises the event and the interrupt; channel 1 untouched
      wb_write(6'h08, 32'd400); m_hi[0] = 400;
      wb_write(6'h09, 32'd200); m_lo[0] = 200;
      wb_write(6'h01, 32'd1);   m_en = 4'b0001;
      repeat (8) push1(0, 450);
      settle();
      chk_glob("high");
      check("event0_high", 32'(m_ev[0]), 32'd1);
      check("irq_high", 32'(irq_o), 32'd1);
      chk_chan(1);

      // between thresholds the event holds, below LO it drops
      repeat (8) push1(0, 300);
      settle();
      chk_glob("mid");
      repeat (8) push1(0, 100);
      settle();
      chk_glob("low");

      // W1C: irq follows status one cycle later
      wb_write(6'h02, 32'd1);
      m_st[0] = 1'b0;
      check("irq_w1c_lag", 32'(irq_o), 32'd1);
      @(posedge clk); #1;
      check("irq_after_w1c", 32'(irq_o), 32'd0);
      rd_chk("status_after_w1c", 6'h02, 32'(m_st));

      // a new event in the same cycle as a W1C of that bit keeps the bit set;
      // the seventh 450 lifts the average from 362 to 406
      repeat (6) push1(0, 450);
      sensor_data_in = '0;
      sensor_data_in[WIDTH-1:0] = WIDTH'(450);
      sensor_valid_in = 4'b0001;
      @(posedge clk); #1;
      sensor_valid_in = '0;
      @(posedge clk); #1;
      m_sample(0, 450);
      wb_write(6'h02, 32'd1);
      settle();
      chk_glob("w1c_race");

      // fill channel 2, then clear with a channel 3 sample in the clear cycle
      for (int k = 0; k < 8; k++) push1(2, int'($urandom_range(0, 1023)));
      settle();
      chk_chan(2);
      sensor_data_in = '0;
      sensor_data_in[3*WIDTH +: WIDTH] = WIDTH'(77);
      sensor_valid_in = 4'b1000;
      wb_write(6'h00, 32'd3);
      sensor_valid_in = '0;
      m_clear();
      settle();
      chk_chan(2);
      chk_chan(3);
      rd_chk("thresh_hi2_kept", 6'h0A - 6'h02 + 6'h08, 32'(m_hi[2]));
      rd_chk("thresh_hi0_kept", 6'h08, 32'(m_hi[0]));
      rd_chk("thresh_lo0_kept", 6'h09, 32'(m_lo[0]));
      rd_chk("irq_en_kept", 6'h01, 32'(m_en));
      chk_glob("clear");

      // unmapped space and absent channels
      rd_chk("unmapped_3f", 6'h3F, 32'd0);
      rd_chk("unmapped_04", 6'h04, 32'd0);
      wb_write(6'h18, 32'd5);
      rd_chk("absent_ch4", 6'h18, 32'd0);

      // enable survives clear
      push1(2, 500);
      settle();
      chk_chan(2);

      // randomized rounds
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < CH; c++) begin
            m_hi[c] = int'($urandom_range(200, 800));
            m_lo[c] = int'($urandom_range(100, 900));
            wb_write(6'(8 + 4*c), 32'(m_hi[c]));
            wb_write(6'(9 + 4*c), 32'(m_lo[c]));
         end
         m_en = CH'($urandom_range(1, 15));
         wb_write(6'h01, 32'(m_en));
         for (int k = 0; k < 24; k++) begin
            vm = CH'($urandom_range(0, 15));
            for (int c = 0; c < CH; c++)
               rd_data[c*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 1023));
            push(vm, rd_data);
         end
         settle();
         for (int c = 0; c < CH; c++) chk_chan(c);
         chk_glob($sformatf("rnd%0d", r));
         mask = CH'($urandom_range(0, 15));
         wb_write(6'h02, 32'(mask));
         m_st = m_st & ~mask;
         settle();
         chk_glob($sformatf("rnd%0d_w1c", r));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
